// File: rtl/thor2024_pc_redirect_arb.sv
// PC-redirect arbiter for the fetch stage: it sequences branch-miss, interrupt and
// backward-branch redirects one at a time, and it fetches the interrupt vector.
module thor2024_pc_redirect_arb #(
  parameter int             PCW     = 32,
  parameter int             UIPW    = 12,
  parameter logic [PCW-1:0] VECBASE = PCW'(32'hFFFC0000),
  parameter int             VEC_TMO = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            miss_req,
  input  logic [PCW-1:0]  miss_pc,
  input  logic            back_req,
  input  logic [PCW-1:0]  back_pc,
  input  logic [UIPW-1:0] back_uip,
  input  logic            irq,
  input  logic [7:0]      irq_cause,
  output logic            vec_rd,
  output logic [PCW-1:0]  vec_adr,
  input  logic            vec_ack,
  input  logic [PCW-1:0]  vec_dat,
  output logic            redir_v,
  output logic [PCW-1:0]  redir_pc,
  output logic [UIPW-1:0] redir_uip,
  input  logic            redir_ack,
  output logic            irq_ack,
  output logic            vec_err,
  output logic            fetch_stall
);

  typedef enum logic [1:0] {IDLE, VRD, VWAIT, ISSUE} state_t;
  typedef enum logic [1:0] {K_MISS, K_BACK, K_IRQ} kind_t;

  localparam logic [3:0] TMO = 4'(VEC_TMO);

  state_t          state, state_n;
  kind_t           kind, kind_n;
  logic            pend_miss, pend_miss_n, pend_back, pend_back_n;
  logic [3:0]      timer, timer_n, timer_inc;
  logic            redir_v_n, vec_err_n;
  logic [PCW-1:0]  redir_pc_n, vec_adr_n;
  logic [UIPW-1:0] redir_uip_n;
  logic [PCW-1:0]  miss_tgt, back_tgt, miss_sel, back_sel;
  logic [UIPW-1:0] back_uip_r, back_uip_sel;

  // A request arriving this cycle is newer than the held one, and it is used directly
  // so that an idle arbiter raises redir_v in the very next cycle.
  assign miss_sel     = miss_req ? miss_pc  : miss_tgt;
  assign back_sel     = back_req ? back_pc  : back_tgt;
  assign back_uip_sel = back_req ? back_uip : back_uip_r;
  assign timer_inc    = (timer == TMO) ? timer : timer + 4'd1;

  always_comb begin
    state_n     = state;
    kind_n      = kind;
    pend_miss_n = pend_miss | miss_req;
    pend_back_n = miss_req ? 1'b0 : (pend_back | back_req);
    timer_n     = timer;
    redir_v_n   = redir_v;
    redir_pc_n  = redir_pc;
    redir_uip_n = redir_uip;
    vec_adr_n   = vec_adr;
    vec_err_n   = vec_err;
    unique case (state)
      IDLE: begin
        // The pending flag is consumed when its target moves into the redirect register.
        // A same-type request that arrives while that redirect is outstanding then stays
        // pending and is issued after the transfer.
        if (pend_miss || miss_req) begin
          state_n     = ISSUE;
          kind_n      = K_MISS;
          redir_v_n   = 1'b1;
          redir_pc_n  = miss_sel;
          redir_uip_n = '0;
          pend_miss_n = 1'b0;
        end else if (irq) begin
          state_n   = VRD;
          vec_adr_n = VECBASE + PCW'({irq_cause, 3'b000});
        end else if (pend_back || back_req) begin
          state_n     = ISSUE;
          kind_n      = K_BACK;
          redir_v_n   = 1'b1;
          redir_pc_n  = back_sel;
          redir_uip_n = back_uip_sel;
          pend_back_n = 1'b0;
        end
      end
      VRD: begin
        timer_n = '0;
        state_n = VWAIT;
      end
      VWAIT: begin
        timer_n = timer_inc;
        if (pend_miss || miss_req) begin
          state_n = IDLE;
        end else if (vec_ack) begin
          state_n     = ISSUE;
          kind_n      = K_IRQ;
          redir_v_n   = 1'b1;
          redir_pc_n  = vec_dat;
          redir_uip_n = '0;
        end else if (timer_inc == TMO) begin
          state_n     = ISSUE;
          kind_n      = K_IRQ;
          redir_v_n   = 1'b1;
          redir_pc_n  = VECBASE;
          redir_uip_n = '0;
          vec_err_n   = 1'b1;
        end
      end
      ISSUE: begin
        if (redir_ack) begin
          state_n   = IDLE;
          redir_v_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      kind      <= K_MISS;
      pend_miss <= 1'b0;
      pend_back <= 1'b0;
      timer     <= '0;
      redir_v   <= 1'b0;
      redir_pc  <= '0;
      redir_uip <= '0;
      vec_adr   <= '0;
      vec_err   <= 1'b0;
    end else begin
      state     <= state_n;
      kind      <= kind_n;
      pend_miss <= pend_miss_n;
      pend_back <= pend_back_n;
      timer     <= timer_n;
      redir_v   <= redir_v_n;
      redir_pc  <= redir_pc_n;
      redir_uip <= redir_uip_n;
      vec_adr   <= vec_adr_n;
      vec_err   <= vec_err_n;
    end
  end

  // Held targets are only meaningful while their pending flag is set, so they are not reset.
  always_ff @(posedge clk) begin
    if (miss_req) miss_tgt <= miss_pc;
    if (back_req && !miss_req) begin
      back_tgt   <= back_pc;
      back_uip_r <= back_uip;
    end
  end

  assign vec_rd      = (state == VRD);
  assign irq_ack     = (state == ISSUE) && redir_ack && (kind == K_IRQ);
  assign fetch_stall = pend_miss | pend_back | (state != IDLE);

endmodule
